decode_iter_scheduler: RTL and testbench

- Sequences decoding iterations for one codeword by driving the write-FSM control pair `iter_rqst` / `iter_termination` and tracking its `busy` status.
- Counts completed iterations and gates each iteration on the syndrome-check result.
- Ends decoding with a single termination pulse on parity success or on reaching `MAX_ITER`.
- Sits between the top-level decoder control and the VNU write FSM.

---
 rtl/decode_ctrl_pkg.sv | 22 ++
 rtl/decode_iter_scheduler_if.sv | 34 +++
 rtl/iter_wdog_cnt.sv | 29 ++
 rtl/decode_iter_scheduler.sv | 142 ++++++++++++++
 tb/tb_decode_iter_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared types and encodings for the decode iteration scheduler.
package decode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_CHECK   = 3'd4,
    ST_TERM    = 3'd5
  } sched_state_t;

  localparam logic [1:0] BUSY_IDLE    = 2'b00;
  localparam logic [1:0] BUSY_RUN     = 2'b01;
  localparam logic [1:0] BUSY_FINISH  = 2'b10;
  localparam logic [1:0] BUSY_ILLEGAL = 2'b11;

  function automatic int iter_cnt_width(input int max_iter);
    return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/decode_iter_scheduler_if.sv
// Control/status bundle between decoder control, the scheduler and the VNU write FSM.
interface decode_iter_scheduler_if
  import decode_ctrl_pkg::*;
#(
  parameter int MAX_ITER = 10
) ();

  localparam int CNT_W = iter_cnt_width(MAX_ITER);

  logic             decode_start;
  logic [1:0]       wr_busy;
  logic             parity_valid;
  logic             parity_ok;
  logic             iter_rqst;
  logic             iter_termination;
  logic [CNT_W-1:0] iter_cnt;
  logic             decode_done;
  logic             decode_success;
  logic             sched_busy;
  logic             wdog_err;

  modport master (
    output decode_start, wr_busy, parity_valid, parity_ok,
    input  iter_rqst, iter_termination, iter_cnt, decode_done,
           decode_success, sched_busy, wdog_err
  );

  modport slave (
    input  decode_start, wr_busy, parity_valid, parity_ok,
    output iter_rqst, iter_termination, iter_cnt, decode_done,
           decode_success, sched_busy, wdog_err
  );

endinterface

// File: rtl/iter_wdog_cnt.sv
// Per-iteration watchdog: down-counter loaded on clr, expires at terminal count zero.
module iter_wdog_cnt #(
  parameter int WDOG_CYCLES = 256
) (
  input  logic write_clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
  localparam logic [W-1:0] LOAD = W'(WDOG_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/decode_iter_scheduler.sv
// Iteration sequencer for one codeword; optional watchdog under ITER_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | waiting for decode_start
// LAUNCH     | iter_rqst high, waiting for write FSM busy
// RUN        | iter_rqst high, waiting for write FSM finish
// RELEASE    | iter_rqst low, waiting for write FSM idle
// CHECK      | waiting for syndrome result
// TERM       | one-cycle termination/done pulse
module decode_iter_scheduler
  import decode_ctrl_pkg::*;
#(
  parameter int MAX_ITER    = 10,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                    write_clk,
  input  logic                    rstn,
  decode_iter_scheduler_if.slave  bus
);

  localparam int CNT_W = iter_cnt_width(MAX_ITER);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q;
  logic             iter_rqst_q, iter_term_q, done_q, success_q, busy_q;
  logic             cnt_inc, success_set;

  generate
    if (WDOG_CYCLES < 1 || MAX_ITER < 1) begin : g_param_range_violation
    end
  endgenerate

`ifdef ITER_WATCHDOG_EN
  logic wdog_clr, wdog_en, wdog_expired, wdog_hit, wdog_err_q;

  assign wdog_en  = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_RELEASE);
  assign wdog_clr = (state_d == ST_LAUNCH) && (state_q != ST_LAUNCH);

  iter_wdog_cnt #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .write_clk (write_clk),
    .rstn      (rstn),
    .clr       (wdog_clr),
    .en        (wdog_en),
    .expired   (wdog_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_inc     = 1'b0;
    success_set = 1'b0;
`ifdef ITER_WATCHDOG_EN
    wdog_hit    = 1'b0;
`endif
    case (state_q)
      ST_IDLE:    if (bus.decode_start) state_d = ST_LAUNCH;
      ST_LAUNCH:  if (bus.wr_busy == BUSY_RUN || bus.wr_busy == BUSY_ILLEGAL) state_d = ST_RUN;
      ST_RUN:     if (bus.wr_busy == BUSY_FINISH) state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (bus.wr_busy == BUSY_IDLE) begin
          state_d = ST_CHECK;
          cnt_inc = 1'b1;
        end
      end
      ST_CHECK: begin
        if (bus.parity_valid) begin
          if (bus.parity_ok) begin
            state_d     = ST_TERM;
            success_set = 1'b1;
          end else if (iter_cnt_q == CNT_MAX) begin
            state_d = ST_TERM;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_TERM:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
`ifdef ITER_WATCHDOG_EN
    // Expiry overrides any handshake progress in the same cycle.
    if (wdog_expired) begin
      state_d  = ST_TERM;
      cnt_inc  = 1'b0;
      wdog_hit = 1'b1;
    end
`endif
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      iter_cnt_q  <= '0;
      iter_rqst_q <= 1'b0;
      iter_term_q <= 1'b0;
      done_q      <= 1'b0;
      success_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_rqst_q <= (state_d == ST_LAUNCH) || (state_d == ST_RUN);
      iter_term_q <= (state_d == ST_TERM);
      done_q      <= (state_d == ST_TERM);
      busy_q      <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && bus.decode_start) begin
        iter_cnt_q <= '0;
        success_q  <= 1'b0;
      end else begin
        if (cnt_inc && iter_cnt_q != CNT_MAX) iter_cnt_q <= iter_cnt_q + CNT_W'(1);
        if (success_set) success_q <= 1'b1;
`ifdef ITER_WATCHDOG_EN
        if (wdog_hit) success_q <= 1'b0;
`endif
      end
    end
  end

`ifdef ITER_WATCHDOG_EN
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      wdog_err_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.decode_start) begin
      wdog_err_q <= 1'b0;
    end else if (wdog_hit) begin
      wdog_err_q <= 1'b1;
    end
  end
  assign bus.wdog_err = wdog_err_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

  assign bus.iter_rqst        = iter_rqst_q;
  assign bus.iter_termination = iter_term_q;
  assign bus.iter_cnt         = iter_cnt_q;
  assign bus.decode_done      = done_q;
  assign bus.decode_success   = success_q;
  assign bus.sched_busy       = busy_q;

endmodule

// File: tb/tb_decode_iter_scheduler.sv
// Self-checking bench for decode_iter_scheduler: vector table, corner sequences, random codewords.
`timescale 1ns/1ps
module tb_decode_iter_scheduler;
  import decode_ctrl_pkg::*;

  localparam int MAX_ITER    = 10;
  localparam int WDOG_CYCLES = 256;

  logic write_clk = 1'b0;
  logic rstn      = 1'b0;
  always #5 write_clk = ~write_clk;

  decode_iter_scheduler_if #(.MAX_ITER(MAX_ITER)) bus ();

  decode_iter_scheduler #(.MAX_ITER(MAX_ITER), .WDOG_CYCLES(WDOG_CYCLES)) dut (
    .write_clk (write_clk),
    .rstn      (rstn),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  int   rqst_rises = 0;
  int   done_cnt   = 0;
  int   term_cnt   = 0;
  logic rqst_prev  = 1'b0;

  always @(negedge write_clk) begin
    if (bus.iter_rqst === 1'b1 && rqst_prev !== 1'b1) rqst_rises++;
    if (bus.decode_done === 1'b1) done_cnt++;
    if (bus.iter_termination === 1'b1) term_cnt++;
    rqst_prev = bus.iter_rqst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: iterations run until parity succeeds or the iteration cap is hit.
  function automatic int model_iters(input int ok_at);
    return (ok_at >= 1 && ok_at <= MAX_ITER) ? ok_at : MAX_ITER;
  endfunction

  function automatic bit model_succ(input int ok_at);
    return (ok_at >= 1 && ok_at <= MAX_ITER);
  endfunction

  task automatic run_cw(input string nm, input int ok_at, input int busy_len, input bit use11,
                        input int fin_hold, input bit noise, input int exp_iters, input bit exp_succ);
    int r0, d0, t0, t;
    r0 = rqst_rises; d0 = done_cnt; t0 = term_cnt;
    bus.decode_start = 1'b1;
    @(negedge write_clk);
    bus.decode_start = 1'b0;
    chk({nm, "_start_rqst"}, bus.iter_rqst, 1);
    chk({nm, "_start_cnt"}, bus.iter_cnt, 0);
    chk({nm, "_start_succ"}, bus.decode_success, 0);
    chk({nm, "_start_wdog"}, bus.wdog_err, 0);
    chk({nm, "_start_busy"}, bus.sched_busy, 1);
    for (int it = 1; it <= exp_iters; it++) begin
      t = 0;
      while (bus.iter_rqst !== 1'b1 && t < 50) begin
        @(negedge write_clk);
        t++;
      end
      if (bus.iter_rqst !== 1'b1) begin
        chk({nm, "_rqst_timeout"}, bus.iter_rqst, 1);
        break;
      end
      bus.wr_busy = use11 ? BUSY_ILLEGAL : BUSY_RUN;
      for (int c = 0; c < busy_len; c++) begin
        @(negedge write_clk);
        if (noise && c == 0) begin
          bus.decode_start = 1'b1; bus.parity_valid = 1'b1; bus.parity_ok = 1'b1;
        end else begin
          bus.decode_start = 1'b0; bus.parity_valid = 1'b0; bus.parity_ok = 1'b0;
        end
      end
      bus.decode_start = 1'b0; bus.parity_valid = 1'b0; bus.parity_ok = 1'b0;
      bus.wr_busy = BUSY_FINISH;
      @(negedge write_clk);
      chk({nm, "_rqst_drop"}, bus.iter_rqst, 0);
      repeat (fin_hold) @(negedge write_clk);
      chk({nm, "_cnt_hold"}, bus.iter_cnt, it - 1);
      bus.wr_busy = BUSY_IDLE;
      @(negedge write_clk);
      chk({nm, "_cnt_inc"}, bus.iter_cnt, it);
      bus.parity_valid = 1'b1;
      bus.parity_ok    = (it == ok_at);
      @(negedge write_clk);
      bus.parity_valid = 1'b0;
      bus.parity_ok    = 1'b0;
      if (it == exp_iters) chk({nm, "_done"}, bus.decode_done, 1);
      else                 chk({nm, "_next_rqst"}, bus.iter_rqst, 1);
    end
    @(negedge write_clk);
    chk({nm, "_iter_cnt"}, bus.iter_cnt, exp_iters);
    chk({nm, "_success"}, bus.decode_success, exp_succ);
    chk({nm, "_idle_busy"}, bus.sched_busy, 0);
    chk({nm, "_idle_rqst"}, bus.iter_rqst, 0);
    chk({nm, "_rqst_periods"}, rqst_rises - r0, exp_iters);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_term_pulses"}, term_cnt - t0, 1);
  endtask

  typedef struct {
    int ok_at;
    int busy_len;
    bit use11;
    int fin_hold;
    bit noise;
    int exp_iters;
    bit exp_succ;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks, expected completion", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int t, t0, ok_at;
    vecs[0] = '{3, 64, 1'b0, 0, 1'b0, 3, 1'b1};    // success on third iteration
    vecs[1] = '{0, 4, 1'b0, 0, 1'b0, 10, 1'b0};    // never succeeds -> cap
    vecs[2] = '{2, 3, 1'b0, 20, 1'b0, 2, 1'b1};    // finish held 20 extra cycles
    vecs[3] = '{10, 2, 1'b0, 0, 1'b1, 10, 1'b1};   // success wins at cap, ignored noise
    vecs[4] = '{1, 1, 1'b1, 0, 1'b0, 1, 1'b1};     // 11 treated as busy
    vecs[5] = '{12, 2, 1'b1, 1, 1'b0, 10, 1'b0};

    bus.decode_start = 1'b0; bus.wr_busy = BUSY_IDLE;
    bus.parity_valid = 1'b0; bus.parity_ok = 1'b0;
    repeat (2) @(negedge write_clk);
    chk("rst_rqst", bus.iter_rqst, 0);
    chk("rst_term", bus.iter_termination, 0);
    chk("rst_cnt", bus.iter_cnt, 0);
    chk("rst_done", bus.decode_done, 0);
    chk("rst_succ", bus.decode_success, 0);
    chk("rst_busy", bus.sched_busy, 0);
    chk("rst_wdog", bus.wdog_err, 0);
    rstn = 1'b1;
    @(negedge write_clk);

    for (int i = 0; i < 6; i++)
      run_cw($sformatf("vec%0d", i), vecs[i].ok_at, vecs[i].busy_len, vecs[i].use11,
             vecs[i].fin_hold, vecs[i].noise, vecs[i].exp_iters, vecs[i].exp_succ);

    // Asynchronous reset during RUN of the second iteration.
    t0 = term_cnt;
    bus.decode_start = 1'b1; @(negedge write_clk); bus.decode_start = 1'b0;
    bus.wr_busy = BUSY_RUN;    repeat (2) @(negedge write_clk);
    bus.wr_busy = BUSY_FINISH; @(negedge write_clk);
    bus.wr_busy = BUSY_IDLE;   @(negedge write_clk);
    bus.parity_valid = 1'b1;   @(negedge write_clk); bus.parity_valid = 1'b0;
    bus.wr_busy = BUSY_RUN;    repeat (2) @(negedge write_clk);
    chk("rstrun_pre_cnt", bus.iter_cnt, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstrun_rqst", bus.iter_rqst, 0);
    chk("rstrun_cnt", bus.iter_cnt, 0);
    chk("rstrun_busy", bus.sched_busy, 0);
    @(negedge write_clk);
    bus.wr_busy = BUSY_IDLE;
    rstn = 1'b1;
    @(negedge write_clk);
    chk("rstrun_no_term", term_cnt - t0, 0);
    run_cw("rstrun_restart", 2, 3, 1'b0, 0, 1'b0, model_iters(2), model_succ(2));

    // Write FSM stuck busy.
    t0 = term_cnt;
    bus.decode_start = 1'b1; @(negedge write_clk); bus.decode_start = 1'b0;
    bus.wr_busy = BUSY_RUN;
`ifdef ITER_WATCHDOG_EN
    t = 0;
    while (bus.iter_termination !== 1'b1 && t < WDOG_CYCLES + 50) begin
      @(negedge write_clk);
      t++;
    end
    chk("wdog_latency", t, WDOG_CYCLES);
    chk("wdog_err_set", bus.wdog_err, 1);
    chk("wdog_succ", bus.decode_success, 0);
    chk("wdog_done", bus.decode_done, 1);
    bus.wr_busy = BUSY_IDLE;
    @(negedge write_clk);
    chk("wdog_idle", bus.sched_busy, 0);
    chk("wdog_sticky", bus.wdog_err, 1);
    chk("wdog_term_pulses", term_cnt - t0, 1);
`else
    t = 0;
    repeat (WDOG_CYCLES + 20) begin
      @(negedge write_clk);
      t++;
    end
    chk("nowdog_term", term_cnt - t0, 0);
    chk("nowdog_err", bus.wdog_err, 0);
    chk("nowdog_busy", bus.sched_busy, 1);
    chk("nowdog_rqst", bus.iter_rqst, 1);
    bus.wr_busy = BUSY_FINISH; @(negedge write_clk);
    bus.wr_busy = BUSY_IDLE;   @(negedge write_clk);
    bus.parity_valid = 1'b1; bus.parity_ok = 1'b1; @(negedge write_clk);
    bus.parity_valid = 1'b0; bus.parity_ok = 1'b0;
    @(negedge write_clk);
    chk("nowdog_recover_succ", bus.decode_success, 1);
    chk("nowdog_recover_idle", bus.sched_busy, 0);
`endif
    run_cw("post_stuck", 1, 2, 1'b0, 0, 1'b0, model_iters(1), model_succ(1));

    for (int n = 0; n < 8; n++) begin
      ok_at = $urandom_range(0, 12);
      run_cw($sformatf("rnd%0d_ok%0d", n, ok_at), ok_at, $urandom_range(1, 8),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             model_iters(ok_at), model_succ(ok_at));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
